// File: rtl/rflp_sram_pkg.sv
// Shared constants, FSM state encoding and byte-lane mask helper for the
// rflp_sram_bw register-file SRAM.
package rflp_sram_pkg;

    localparam int DEF_DW  = 32;
    localparam int DEF_BW  = 8;
    localparam int DEF_RAW = 6;
    localparam int DEF_CAW = 2;

    // Widest word the mask helper can expand; callers size-cast the result.
    localparam int MAX_DW = 256;
    localparam int MAX_NB = MAX_DW;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CLR  = 1'b1
    } state_e;

    // Active-low lane enables in, active-high per-bit write mask out.
    function automatic logic [MAX_DW-1:0] lane_mask(input logic [MAX_NB-1:0] nbwe,
                                                    input int bw);
        logic [MAX_DW-1:0] m;
        for (int b = 0; b < MAX_DW; b++) begin
            m[b] = ~nbwe[b / bw];
        end
        return m;
    endfunction

endpackage

// File: rtl/rflp_sram_bw_if.sv
// Access/status bus of rflp_sram_bw; master drives requests, slave is the SRAM.
interface rflp_sram_bw_if
    import rflp_sram_pkg::*;
#(
    parameter int DW  = DEF_DW,
    parameter int BW  = DEF_BW,
    parameter int RAW = DEF_RAW,
    parameter int CAW = DEF_CAW
) ();

    localparam int NB = DW / BW;

    logic [DW-1:0]  DIN;
    logic [RAW-1:0] RA;
    logic [CAW-1:0] CA;
    logic           NCE;
    logic           NWRT;
    logic [NB-1:0]  NBWE;
    logic           NCLR;
    logic [DW-1:0]  DO;
    logic           DVALID;
    logic           BUSY;
    logic           ERR;

    modport master (
        output DIN, RA, CA, NCE, NWRT, NBWE, NCLR,
        input  DO, DVALID, BUSY, ERR
    );

    modport slave (
        input  DIN, RA, CA, NCE, NWRT, NBWE, NCLR,
        output DO, DVALID, BUSY, ERR
    );

endinterface

// File: rtl/rflp_sram_array.sv
// DEPTH x DW storage with a bit-masked synchronous write and a registered,
// read-before-write read port.
module rflp_sram_array #(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [DW-1:0] wmask,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array and its read register carry no reset so they map onto
    // plain RAM; zeroing is the clear sweep's job, not the reset network's.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/rflp_sram_bw.sv
// Register-file SRAM with byte write enables, optional write-through, a
// hardware zero-clear sweep, and BUSY/DVALID/ERR status.
module rflp_sram_bw
    import rflp_sram_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int BW       = DEF_BW,
    parameter int RAW      = DEF_RAW,
    parameter int CAW      = DEF_CAW,
    parameter bit INIT_CLR = 1'b1,
    parameter bit WR_THRU  = 1'b0
) (
    input  logic           CLK,
    input  logic           NRST,
    rflp_sram_bw_if.slave  bus
);

    localparam int AW = RAW + CAW;
    localparam logic [0:0] IDLE = S_IDLE;
    localparam logic [0:0] CLR  = S_CLR;

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          idle;
    logic          acc;
    logic          rd;
    logic          wr;
    logic          thru;
    logic [DW-1:0] lane_bits;
    logic          arr_we;
    logic          arr_re;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_wmask;
    logic [DW-1:0] arr_rdata;
    logic [DW-1:0] din_q;
    logic [DW-1:0] mask_q;
    logic          dvalid;
    logic          err;

    assign idle      = (state == IDLE);
    assign acc       = idle && !bus.NCE;
    assign rd        = acc && bus.NWRT;
    assign wr        = acc && !bus.NWRT;
    assign thru      = wr && WR_THRU;
    assign lane_bits = DW'(lane_mask(MAX_NB'(bus.NBWE), BW));

    // The sweep owns the single port while it runs.
    assign arr_we    = wr || !idle;
    assign arr_re    = rd || thru;
    assign arr_addr  = idle ? {bus.RA, bus.CA} : cnt;
    assign arr_wdata = idle ? bus.DIN : '0;
    assign arr_wmask = idle ? lane_bits : '1;

    rflp_sram_array #(
        .DW (DW),
        .AW (AW)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .wmask (arr_wmask),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .re    (arr_re),
        .rdata (arr_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, matching the hardware regardless of block ordering.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state <= INIT_CLR ? CLR : IDLE;
            cnt   <= '0;
        end else if (state == CLR) begin
            cnt <= cnt + AW'(1);
            if (cnt == '1) begin
                state <= IDLE;
            end
        end else if (!bus.NCLR) begin
            state <= CLR;
            cnt   <= '0;
        end
    end

    // DO is the captured old word with the written lanes overlaid: reads
    // clear the overlay, write-through loads it, reset selects all-zero data.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            din_q  <= '0;
            mask_q <= '1;
            dvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            dvalid <= rd || thru;
            if (rd) begin
                mask_q <= '0;
            end else if (thru) begin
                din_q  <= bus.DIN;
                mask_q <= lane_bits;
            end
            if (!idle && !bus.NCE) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.DO     = (arr_rdata & ~mask_q) | (din_q & mask_q);
    assign bus.DVALID = dvalid;
    assign bus.BUSY   = (state == CLR);
    assign bus.ERR    = err;

endmodule

// File: tb/tb_rflp_sram_bw.sv
// Directed self-checking bench: dut_a is the default build, dut_b has WR_THRU=1.
module tb_rflp_sram_bw;

    logic CLK = 1'b0;
    logic NRST;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 CLK = ~CLK;

    rflp_sram_bw_if #(.DW(32), .BW(8), .RAW(6), .CAW(2)) bus_a ();
    rflp_sram_bw_if #(.DW(32), .BW(8), .RAW(6), .CAW(2)) bus_b ();

    rflp_sram_bw #(
        .DW(32), .BW(8), .RAW(6), .CAW(2), .INIT_CLR(1'b1), .WR_THRU(1'b0)
    ) dut_a (
        .CLK  (CLK),
        .NRST (NRST),
        .bus  (bus_a)
    );

    rflp_sram_bw #(
        .DW(32), .BW(8), .RAW(6), .CAW(2), .INIT_CLR(1'b1), .WR_THRU(1'b1)
    ) dut_b (
        .CLK  (CLK),
        .NRST (NRST),
        .bus  (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        bus_a.NCE  = 1'b1;
        bus_a.NWRT = 1'b1;
        bus_a.NBWE = 4'hF;
        bus_a.NCLR = 1'b1;
    endtask

    task automatic idle_b();
        bus_b.NCE  = 1'b1;
        bus_b.NWRT = 1'b1;
        bus_b.NBWE = 4'hF;
        bus_b.NCLR = 1'b1;
    endtask

    task automatic acc_a(input logic nwrt, input logic [7:0] addr,
                         input logic [3:0] nbwe, input logic [31:0] din);
        bus_a.NCE  = 1'b0;
        bus_a.NWRT = nwrt;
        bus_a.RA   = addr[7:2];
        bus_a.CA   = addr[1:0];
        bus_a.NBWE = nbwe;
        bus_a.DIN  = din;
        tick();
        idle_a();
    endtask

    task automatic acc_b(input logic nwrt, input logic [7:0] addr,
                         input logic [3:0] nbwe, input logic [31:0] din);
        bus_b.NCE  = 1'b0;
        bus_b.NWRT = nwrt;
        bus_b.RA   = addr[7:2];
        bus_b.CA   = addr[1:0];
        bus_b.NBWE = nbwe;
        bus_b.DIN  = din;
        tick();
        idle_b();
    endtask

    // Counts edges until dut_a drops BUSY, bounded so a stuck sweep still ends.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (bus_a.BUSY && cnt < 400);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rd_addrs [3];
        rd_addrs[0] = 8'h00;
        rd_addrs[1] = 8'h7F;
        rd_addrs[2] = 8'hFF;

        NRST = 1'b0;
        idle_a();
        idle_b();
        bus_a.DIN = '0; bus_a.RA = '0; bus_a.CA = '0;
        bus_b.DIN = '0; bus_b.RA = '0; bus_b.CA = '0;
        #12;
        check("rst_do",     bus_a.DO, 32'h0);
        check("rst_dvalid", bus_a.DVALID, 1'b0);
        check("rst_err",    bus_a.ERR, 1'b0);
        check("rst_busy",   bus_a.BUSY, 1'b1);
        check("rst_busy_b", bus_b.BUSY, 1'b1);
        NRST = 1'b1;

        wait_idle(n);
        check("init_sweep_len", n, 256);
        check("init_busy_b", bus_b.BUSY, 1'b0);

        for (int i = 0; i < 3; i++) begin
            acc_a(1'b1, rd_addrs[i], 4'hF, 32'h0);
            check("clr_read_do", bus_a.DO, 32'h0);
            check("clr_read_dv", bus_a.DVALID, 1'b1);
        end
        tick();
        check("dv_drop", bus_a.DVALID, 1'b0);

        acc_a(1'b0, 8'h56, 4'b0000, 32'hDEADBEEF);
        check("wr_no_dv", bus_a.DVALID, 1'b0);
        check("wr_do_hold", bus_a.DO, 32'h0);
        acc_a(1'b0, 8'h56, 4'b1010, 32'h11223344);
        acc_a(1'b1, 8'h56, 4'hF, 32'h0);
        check("byte_merge", bus_a.DO, 32'hDE22BE44);
        check("byte_merge_dv", bus_a.DVALID, 1'b1);

        acc_a(1'b0, 8'h10, 4'b0000, 32'hCAFEF00D);
        acc_a(1'b1, 8'h10, 4'hF, 32'h0);
        check("hold_rd", bus_a.DO, 32'hCAFEF00D);
        check("hold_rd_dv", bus_a.DVALID, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_do", bus_a.DO, 32'hCAFEF00D);
            check("hold_dv", bus_a.DVALID, 1'b0);
        end

        acc_b(1'b0, 8'h0D, 4'b0000, 32'hA5A5A5A5);
        check("wt_do", bus_b.DO, 32'hA5A5A5A5);
        check("wt_dv", bus_b.DVALID, 1'b1);
        acc_b(1'b0, 8'h0D, 4'b1110, 32'h000000FF);
        check("wt_merge", bus_b.DO, 32'hA5A5A5FF);
        acc_b(1'b1, 8'h0D, 4'hF, 32'h0);
        check("wt_readback", bus_b.DO, 32'hA5A5A5FF);
        tick();
        check("wt_dv_drop", bus_b.DVALID, 1'b0);
        check("wt_hold", bus_b.DO, 32'hA5A5A5FF);

        bus_a.NCLR = 1'b0;
        tick();
        idle_a();
        check("clr_start", bus_a.BUSY, 1'b1);
        repeat (9) tick();
        acc_a(1'b0, 8'h02, 4'b0000, 32'h55555555);
        check("busy_err", bus_a.ERR, 1'b1);
        check("busy_no_dv", bus_a.DVALID, 1'b0);
        check("busy_do_hold", bus_a.DO, 32'hCAFEF00D);
        wait_idle(n);
        check("busy_sweep_rest", n, 246);
        check("err_sticky", bus_a.ERR, 1'b1);
        acc_a(1'b1, 8'h02, 4'hF, 32'h0);
        check("busy_write_dropped", bus_a.DO, 32'h0);
        acc_a(1'b1, 8'h56, 4'hF, 32'h0);
        check("swept_word", bus_a.DO, 32'h0);
        check("err_still", bus_a.ERR, 1'b1);

        bus_a.NCLR = 1'b0;
        tick();
        idle_a();
        repeat (99) tick();
        NRST = 1'b0;
        #2;
        check("mid_rst_err", bus_a.ERR, 1'b0);
        check("mid_rst_busy", bus_a.BUSY, 1'b1);
        check("mid_rst_do", bus_a.DO, 32'h0);
        check("mid_rst_dv", bus_a.DVALID, 1'b0);
        NRST = 1'b1;
        wait_idle(n);
        check("restart_sweep_len", n, 256);
        check("restart_err", bus_a.ERR, 1'b0);

        bus_a.NCLR = 1'b0; bus_a.NCE = 1'b0; bus_a.NWRT = 1'b0;
        bus_a.RA = 6'h1F; bus_a.CA = 2'd3; bus_a.NBWE = 4'h0; bus_a.DIN = 32'h12345678;
        bus_b.NCLR = 1'b0; bus_b.NCE = 1'b0; bus_b.NWRT = 1'b0;
        bus_b.RA = 6'h1F; bus_b.CA = 2'd3; bus_b.NBWE = 4'h0; bus_b.DIN = 32'h12345678;
        tick();
        idle_a();
        idle_b();
        check("same_edge_busy", bus_a.BUSY, 1'b1);
        check("same_edge_err", bus_a.ERR, 1'b0);
        check("same_edge_dv", bus_a.DVALID, 1'b0);
        check("same_edge_wt", bus_b.DO, 32'h12345678);
        check("same_edge_wt_dv", bus_b.DVALID, 1'b1);
        check("same_edge_err_b", bus_b.ERR, 1'b0);
        wait_idle(n);
        check("same_edge_sweep_len", n, 256);
        acc_a(1'b1, 8'h7F, 4'hF, 32'h0);
        check("same_edge_cleared", bus_a.DO, 32'h0);
        check("same_edge_cleared_dv", bus_a.DVALID, 1'b1);
        check("same_edge_err_end", bus_a.ERR, 1'b0);
        acc_b(1'b1, 8'h7F, 4'hF, 32'h0);
        check("same_edge_cleared_b", bus_b.DO, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
